half_duplex_port: RTL and testbench
===================================

HALF_DUPLEX_PORT -- requirements
Module: half_duplex_port

Interface
REQ-001 Parameter TURN_CYC, default 2: number of bus-idle turnaround cycles inserted on every direction change; the legal range is 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tx_valid  input  1  upstream has a word to drive onto the bus.
REQ-005 tx_data  input  8  word to drive.
REQ-006 tx_ready  output  1  port accepts tx_data this cycle.
REQ-007 rx_req  input  1  request to sample the bus.
REQ-008 rx_valid  output  1  rx_data holds a fresh sample (one-cycle pulse per sample).
REQ-009 rx_data  output  8  sampled bus word.
REQ-010 dir  output  1  1 = port is driving the bus, 0 = bus released.
REQ-011 bus  inout  8  shared tristate bus; equals data_q when dir=1, else 8'bz.
REQ-012 contention_err  output  1  sticky flag set when a driven bus value is not read back (see Configuration).

Function
REQ-013 The FSM SHALL use four states: IDLE, TURN, DRV and SMP; a register last_dir records the most recent direction (TX or RX).
REQ-014 IDLE: bus released; tx_valid has priority over rx_req.
  - On tx_valid, go to DRV if last_dir==TX, else go to TURN with target TX.
  - On rx_req alone, go to SMP if last_dir==RX, else go to TURN with target RX.
REQ-015 TURN: bus released and tx_ready=0.
  - Remain in TURN for exactly TURN_CYC cycles using a 4-bit down-counter.
  - Then enter the target state and update last_dir to the target.
REQ-016 DRV: tx_ready=1 (combinational on state).
  - Each cycle with tx_valid=1: data_q<=tx_data and dir<=1, so the word appears on the bus the cycle after acceptance; back-to-back words stream one per cycle.
  - On the first cycle in DRV with tx_valid=0: dir<=0 and go to IDLE.
REQ-017 SMP: each cycle with rx_req=1, rx_data<=bus and rx_valid<=1 on the next cycle.
  - On rx_req=0, go to IDLE.
  - On tx_valid=1 (even while rx_req=1), go to IDLE so that TX priority and turnaround apply.
REQ-018 rx_valid SHALL be 0 in every cycle not immediately following an SMP sample.
REQ-019 dir SHALL never be 1 outside DRV or the single release cycle that follows DRV; the bus SHALL be released for at least TURN_CYC full cycles between the last RX sample and the first driven word.
REQ-020 tx_ready SHALL be 0 in IDLE, TURN and SMP; words are never dropped or duplicated.

Reset
REQ-021 rst_n low SHALL immediately and asynchronously force dir=0 (bus released, including mid-transfer).
REQ-022 rst_n low SHALL also force: state=IDLE, last_dir=RX, turnaround counter=0, data_q=0, rx_data=0, rx_valid=0, contention_err=0.
REQ-023 After reset release, the first transmit SHALL pass through TURN; the first receive SHALL NOT.

Configuration
REQ-024 The macro HDX_CONTENTION_EN SHALL control contention checking.
  - Defined: in every cycle with dir=1, bus is compared with data_q; a mismatch (including X or Z) sets contention_err, which stays set until reset.
  - Undefined: the compare logic is absent and contention_err is tied 0.

Verification
REQ-025 Reset, then rx_req=1 for 3 cycles with the bus driven externally to 8'hA5 -> SMP entered with no TURN; rx_valid pulses 3 times with rx_data=8'hA5; dir=0 throughout.
REQ-026 After the RX in REQ-025, tx_valid=1 with 8'h3C, 8'h3D -> exactly TURN_CYC=2 cycles of tx_ready=0 and bus=Z; then the bus shows 3C and 3D on consecutive cycles; dir drops one cycle after tx_valid falls.
REQ-027 tx_valid and rx_req asserted together in IDLE with last_dir=RX -> TX wins via TURN; no rx_valid pulse occurs.
REQ-028 rst_n pulled low mid-DRV between clock edges -> dir=0 and bus=Z before the next edge; all outputs at reset values.
REQ-029 With HDX_CONTENTION_EN defined, the bench forces the bus to 8'h00 while the port drives 8'hFF -> contention_err=1 and it persists; without the macro, contention_err stays 0.
REQ-030 TURN_CYC=1 and TURN_CYC=15 builds, each doing one RX-to-TX switch -> the turnaround is exactly 1 and 15 cycles respectively.

Source files
------------

// File: rtl/half_duplex_port.sv
// half_duplex_port: one side of a shared 8-bit tristate bus.
// It arbitrates between transmit (drive) and receive (sample) traffic, and
// it inserts TURN_CYC idle cycles whenever the bus changes direction.
// Optional feature macro: HDX_CONTENTION_EN. When it is defined, the port
// reads back the driven bus value and raises a sticky contention_err flag
// if the value differs from the driven word.
module half_duplex_port #(
   parameter int unsigned TURN_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       rx_req,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       dir,
   inout  wire  [7:0] bus,
   output logic       contention_err
);

   typedef enum logic [1:0] {IDLE, TURN, DRV, SMP} state_t;
   typedef enum logic {DIR_RX = 1'b0, DIR_TX = 1'b1} dir_t;

   localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC);

   state_t     r_state;
   dir_t       r_lastDir;
   dir_t       r_target;
   logic [3:0] r_turnCnt;
   logic [7:0] r_dataQ;
   logic       r_dir;
   logic [7:0] r_rxData;
   logic       r_rxValid;

   // The port owns the bus only while dir is high; otherwise it floats.
   assign bus      = r_dir ? r_dataQ : 8'bz;
   assign dir      = r_dir;
   assign rx_valid = r_rxValid;
   assign rx_data  = r_rxData;
   assign tx_ready = (r_state == DRV);

   // Main FSM: direction arbitration, turnaround timing, driving and sampling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_lastDir <= DIR_RX;
         r_target  <= DIR_RX;
         r_turnCnt <= 4'd0;
         r_dataQ   <= 8'd0;
         r_dir     <= 1'b0;
         r_rxData  <= 8'd0;
         r_rxValid <= 1'b0;
      end else begin
         r_rxValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (tx_valid) begin
                  if (r_lastDir == DIR_TX) begin
                     r_state <= DRV;
                  end else begin
                     r_state   <= TURN;
                     r_target  <= DIR_TX;
                     r_turnCnt <= TURN_LOAD;
                  end
               end else if (rx_req) begin
                  if (r_lastDir == DIR_RX) begin
                     r_state <= SMP;
                  end else begin
                     r_state   <= TURN;
                     r_target  <= DIR_RX;
                     r_turnCnt <= TURN_LOAD;
                  end
               end
            end
            TURN: begin
               if (r_turnCnt <= 4'd1) begin
                  r_turnCnt <= 4'd0;
                  r_lastDir <= r_target;
                  r_state   <= (r_target == DIR_TX) ? DRV : SMP;
               end else begin
                  r_turnCnt <= r_turnCnt - 4'd1;
               end
            end
            DRV: begin
               if (tx_valid) begin
                  r_dataQ <= tx_data;
                  r_dir   <= 1'b1;
               end else begin
                  r_dir   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            SMP: begin
               if (tx_valid || !rx_req) begin
                  r_state <= IDLE;
               end else begin
                  r_rxData  <= bus;
                  r_rxValid <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef HDX_CONTENTION_EN
   logic r_contErr;
   logic w_busMatch;

   assign w_busMatch     = (bus == r_dataQ);
   assign contention_err = r_contErr;

   // Sticky readback check; an unresolved (X/Z) compare falls to the error branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_contErr <= 1'b0;
      end else if (r_dir) begin
         if (w_busMatch) begin
            r_contErr <= r_contErr;
         end else begin
            r_contErr <= 1'b1;
         end
      end
   end
`else
   assign contention_err = 1'b0;
`endif

endmodule

// File: tb/tb_half_duplex_port.sv
// Testbench for half_duplex_port: directed scenarios with hand-computed
// expectations. Three instances run side by side (TURN_CYC = 2, 1, 15) so
// that the turnaround width can be measured for all three in one build.
module tb_half_duplex_port;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       txValid = 1'b0;
   logic [7:0] txData = 8'd0;
   logic       rxReq = 1'b0;
   logic       tbDrvEn = 1'b0;
   logic [7:0] tbDrvVal = 8'd0;

   logic       txReady2, rxValid2, dir2, contErr2;
   logic [7:0] rxData2;
   wire  [7:0] bus2;
   logic       txReady1, rxValid1, dir1, contErr1;
   logic [7:0] rxData1;
   wire  [7:0] bus1;
   logic       txReady15, rxValid15, dir15, contErr15;
   logic [7:0] rxData15;
   wire  [7:0] bus15;

   int checks = 0;
   int passes = 0;

`ifdef HDX_CONTENTION_EN
   localparam logic EXP_CONT = 1'b1;
`else
   localparam logic EXP_CONT = 1'b0;
`endif

   // The bench plays the remote bus agent on every instance's bus.
   assign bus2  = tbDrvEn ? tbDrvVal : 8'bz;
   assign bus1  = tbDrvEn ? tbDrvVal : 8'bz;
   assign bus15 = tbDrvEn ? tbDrvVal : 8'bz;

   always #5 clk = ~clk;

   half_duplex_port #(.TURN_CYC(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_valid(txValid), .tx_data(txData),
      .tx_ready(txReady2), .rx_req(rxReq), .rx_valid(rxValid2),
      .rx_data(rxData2), .dir(dir2), .bus(bus2), .contention_err(contErr2));

   half_duplex_port #(.TURN_CYC(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(txValid), .tx_data(txData),
      .tx_ready(txReady1), .rx_req(rxReq), .rx_valid(rxValid1),
      .rx_data(rxData1), .dir(dir1), .bus(bus1), .contention_err(contErr1));

   half_duplex_port #(.TURN_CYC(15)) u_dut15 (
      .clk(clk), .rst_n(rst_n), .tx_valid(txValid), .tx_data(txData),
      .tx_ready(txReady15), .rx_req(rxReq), .rx_valid(rxValid15),
      .rx_data(rxData15), .dir(dir15), .bus(bus15), .contention_err(contErr15));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      txValid = v;
      txData  = d;
      rxReq   = r;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      tbDrvEn = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      repeat (2) tick();
      checks++; if (dir2 !== 1'b0) $display("[TB] FAIL reset_dir: got %b expected 0", dir2); else passes++;
      checks++; if (rxValid2 !== 1'b0) $display("[TB] FAIL reset_rx_valid: got %b expected 0", rxValid2); else passes++;
      checks++; if (rxData2 !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h expected 00", rxData2); else passes++;
      checks++; if (txReady2 !== 1'b0) $display("[TB] FAIL reset_tx_ready: got %b expected 0", txReady2); else passes++;
      checks++; if (contErr2 !== 1'b0) $display("[TB] FAIL reset_contention: got %b expected 0", contErr2); else passes++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_rx_first();
      tbDrvVal = 8'hA5;
      tbDrvEn  = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1);
      tick();
      checks++; if (rxValid2 !== 1'b0) $display("[TB] FAIL rx_enter_valid: got %b expected 0", rxValid2); else passes++;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (rxValid2 !== 1'b1) $display("[TB] FAIL rx_pulse%0d: got %b expected 1", i, rxValid2); else passes++;
         checks++; if (rxData2 !== 8'hA5) $display("[TB] FAIL rx_data%0d: got %h expected a5", i, rxData2); else passes++;
         checks++; if (dir2 !== 1'b0) $display("[TB] FAIL rx_dir%0d: got %b expected 0", i, dir2); else passes++;
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      tbDrvEn = 1'b0;
      tick();
      checks++; if (rxValid2 !== 1'b0) $display("[TB] FAIL rx_end_valid: got %b expected 0", rxValid2); else passes++;
   endtask

   task automatic test_tx_after_rx();
      applyStimulus(1'b1, 8'h3C, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (txReady2 !== 1'b0) $display("[TB] FAIL turn_ready%0d: got %b expected 0", i, txReady2); else passes++;
         checks++; if (dir2 !== 1'b0) $display("[TB] FAIL turn_dir%0d: got %b expected 0", i, dir2); else passes++;
      end
      tick();
      checks++; if (txReady2 !== 1'b1) $display("[TB] FAIL drv_ready: got %b expected 1", txReady2); else passes++;
      tick();
      checks++; if (dir2 !== 1'b1) $display("[TB] FAIL tx_dir_on: got %b expected 1", dir2); else passes++;
      checks++; if (bus2 !== 8'h3C) $display("[TB] FAIL tx_word0: got %h expected 3c", bus2); else passes++;
      applyStimulus(1'b1, 8'h3D, 1'b0);
      tick();
      checks++; if (bus2 !== 8'h3D) $display("[TB] FAIL tx_word1: got %h expected 3d", bus2); else passes++;
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      checks++; if (dir2 !== 1'b0) $display("[TB] FAIL tx_dir_off: got %b expected 0", dir2); else passes++;
      checks++; if (txReady2 !== 1'b0) $display("[TB] FAIL tx_idle_ready: got %b expected 0", txReady2); else passes++;
   endtask

   task automatic test_priority();
      doReset();
      tbDrvVal = 8'hA5;
      tbDrvEn  = 1'b1;
      applyStimulus(1'b1, 8'h5A, 1'b1);
      tick();
      checks++; if (txReady2 !== 1'b0) $display("[TB] FAIL prio_turn_ready: got %b expected 0", txReady2); else passes++;
      checks++; if (rxValid2 !== 1'b0) $display("[TB] FAIL prio_rx0: got %b expected 0", rxValid2); else passes++;
      tick();
      checks++; if (rxValid2 !== 1'b0) $display("[TB] FAIL prio_rx1: got %b expected 0", rxValid2); else passes++;
      tick();
      checks++; if (txReady2 !== 1'b1) $display("[TB] FAIL prio_drv_ready: got %b expected 1", txReady2); else passes++;
      tbDrvEn = 1'b0;
      tick();
      checks++; if (bus2 !== 8'h5A) $display("[TB] FAIL prio_word: got %h expected 5a", bus2); else passes++;
      checks++; if (rxValid2 !== 1'b0) $display("[TB] FAIL prio_rx3: got %b expected 0", rxValid2); else passes++;
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
   endtask

   task automatic test_reset_mid_drv();
      applyStimulus(1'b1, 8'h77, 1'b0);
      tick();
      tick();
      checks++; if (bus2 !== 8'h77) $display("[TB] FAIL middrv_word: got %h expected 77", bus2); else passes++;
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (dir2 !== 1'b0) $display("[TB] FAIL async_dir: got %b expected 0", dir2); else passes++;
      checks++; if (txReady2 !== 1'b0) $display("[TB] FAIL async_ready: got %b expected 0", txReady2); else passes++;
      checks++; if (rxValid2 !== 1'b0) $display("[TB] FAIL async_rx_valid: got %b expected 0", rxValid2); else passes++;
      checks++; if (rxData2 !== 8'h00) $display("[TB] FAIL async_rx_data: got %h expected 00", rxData2); else passes++;
      checks++; if (contErr2 !== 1'b0) $display("[TB] FAIL async_contention: got %b expected 0", contErr2); else passes++;
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_contention();
      doReset();
      applyStimulus(1'b1, 8'hFF, 1'b0);
      repeat (4) tick();
      checks++; if (contErr2 !== 1'b0) $display("[TB] FAIL contention_clean: got %b expected 0", contErr2); else passes++;
      tbDrvVal = 8'h00;
      tbDrvEn  = 1'b1;
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      tbDrvEn = 1'b0;
      tick();
      checks++; if (contErr2 !== EXP_CONT) $display("[TB] FAIL contention_set: got %b expected %b", contErr2, EXP_CONT); else passes++;
      repeat (2) tick();
      checks++; if (contErr2 !== EXP_CONT) $display("[TB] FAIL contention_sticky: got %b expected %b", contErr2, EXP_CONT); else passes++;
   endtask

   task automatic test_turn_widths();
      int  c2 = 0, c1 = 0, c15 = 0;
      bit  d2 = 0, d1 = 0, d15 = 0;
      doReset();
      tbDrvVal = 8'hA5;
      tbDrvEn  = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1);
      repeat (2) tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      tbDrvEn = 1'b0;
      tick();
      applyStimulus(1'b1, 8'h11, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!d2)  begin if (txReady2)  d2  = 1; else c2++;  end
         if (!d1)  begin if (txReady1)  d1  = 1; else c1++;  end
         if (!d15) begin if (txReady15) d15 = 1; else c15++; end
      end
      checks++; if (c2 !== 2) $display("[TB] FAIL turn_width2: got %0d expected 2", c2); else passes++;
      checks++; if (c1 !== 1) $display("[TB] FAIL turn_width1: got %0d expected 1", c1); else passes++;
      checks++; if (c15 !== 15) $display("[TB] FAIL turn_width15: got %0d expected 15", c15); else passes++;
      applyStimulus(1'b0, 8'h00, 1'b0);
      repeat (2) tick();
   endtask

   // Scenario sequence; each task leaves the port idle for the next one.
   initial begin
      test_reset();
      test_rx_first();
      test_tx_after_rx();
      test_priority();
      test_reset_mid_drv();
      test_contention();
      test_turn_widths();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
